// File: rtl/io_bus_master.sv
// io_bus_master
// Initiator for the internal 32-bit register bus. It takes one read or
// write command at a time and runs a two-phase four-edge handshake against
// whichever subsystem decodes the address. Phase 1 transfers the data word
// and phase 2 transfers the status word. It then returns read data and
// status. If no subsystem answers, it returns a timeout flag instead.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_rw              1 = read from subsystem, 0 = write to subsystem
//   cmd_addr/wdata      register number and write data
//   rsp_valid/ready     response handshake
//   rsp_data/status     read data (0 on write/timeout), subsystem status
//   rsp_timeout         transaction aborted, no responder
//   bus_reg_address     register address to the shared bus
//   bus_RW              direction to the shared bus
//   bus_data_out        write data to subsystems
//   bus_data_in         word driven by the selected subsystem
//   bus_handshake_1     master strobe
//   bus_handshake_2     subsystem acknowledge
module io_bus_master #(
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_rw,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]           cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_data,
   output logic [31:0]           rsp_status,
   output logic                  rsp_timeout,
   output logic [ADDR_WIDTH-1:0] bus_reg_address,
   output logic                  bus_RW,
   output logic [31:0]           bus_data_out,
   input  logic [31:0]           bus_data_in,
   output logic                  bus_handshake_1,
   input  logic                  bus_handshake_2
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_D_REQ = 3'd1,
      ST_D_REL = 3'd2,
      ST_S_REQ = 3'd3,
      ST_S_REL = 3'd4,
      ST_ABORT = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   state_t                state_q,       state_d;
   logic [TW-1:0]         timer_q,       timer_d;
   logic                  cmd_ready_q,   cmd_ready_d;
   logic                  rsp_valid_q,   rsp_valid_d;
   logic [31:0]           rsp_data_q,    rsp_data_d;
   logic [31:0]           rsp_status_q,  rsp_status_d;
   logic                  rsp_timeout_q, rsp_timeout_d;
   logic [ADDR_WIDTH-1:0] addr_q,        addr_d;
   logic                  rw_q,          rw_d;
   logic [31:0]           wdata_q,       wdata_d;
   logic                  hs1_q,         hs1_d;
   logic                  timeout_hit_s;
   logic                  counting_s;

   // Final count value: the cycle on which the waited-for edge is still
   // missing. A handshake edge seen on that same cycle still wins.
   assign timeout_hit_s = (timer_q == TW'(TIMEOUT_CYCLES - 1));
   assign counting_s    = (state_q == ST_D_REQ) || (state_q == ST_D_REL) ||
                          (state_q == ST_S_REQ) || (state_q == ST_S_REL) ||
                          (state_q == ST_ABORT);

   // State and output registers; reset drops the strobe asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         timer_q       <= {TW{1'b0}};
         cmd_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= 32'h0000_0000;
         rsp_status_q  <= 32'h0000_0000;
         rsp_timeout_q <= 1'b0;
         addr_q        <= {ADDR_WIDTH{1'b0}};
         rw_q          <= 1'b0;
         wdata_q       <= 32'h0000_0000;
         hs1_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         cmd_ready_q   <= cmd_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_status_q  <= rsp_status_d;
         rsp_timeout_q <= rsp_timeout_d;
         addr_q        <= addr_d;
         rw_q          <= rw_d;
         wdata_q       <= wdata_d;
         hs1_q         <= hs1_d;
      end
   end

   // Next-state and next-output logic for the handshake sequencer.
   always_comb begin
      state_d       = state_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_data_d    = rsp_data_q;
      rsp_status_d  = rsp_status_q;
      rsp_timeout_d = rsp_timeout_q;
      addr_d        = addr_q;
      rw_d          = rw_q;
      wdata_d       = wdata_q;
      hs1_d         = hs1_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               addr_d        = cmd_addr;
               rw_d          = cmd_rw;
               wdata_d       = cmd_wdata;
               hs1_d         = 1'b1;
               // Clear the previous response so a write reports zero data.
               rsp_data_d    = 32'h0000_0000;
               rsp_status_d  = 32'h0000_0000;
               rsp_timeout_d = 1'b0;
               state_d       = ST_D_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_D_REQ: begin
            if (bus_handshake_2) begin
               if (rw_q) begin
                  rsp_data_d = bus_data_in;
               end else begin
                  rsp_data_d = 32'h0000_0000;
               end
               hs1_d   = 1'b0;
               state_d = ST_D_REL;
            end else if (timeout_hit_s) begin
               hs1_d        = 1'b0;
               rsp_data_d   = 32'h0000_0000;
               rsp_status_d = 32'h0000_0000;
               state_d      = ST_ABORT;
            end else begin
               state_d = ST_D_REQ;
            end
         end
         ST_D_REL: begin
            if (!bus_handshake_2) begin
               hs1_d   = 1'b1;
               state_d = ST_S_REQ;
            end else if (timeout_hit_s) begin
               hs1_d        = 1'b0;
               rsp_data_d   = 32'h0000_0000;
               rsp_status_d = 32'h0000_0000;
               state_d      = ST_ABORT;
            end else begin
               state_d = ST_D_REL;
            end
         end
         ST_S_REQ: begin
            if (bus_handshake_2) begin
               rsp_status_d = bus_data_in;
               hs1_d        = 1'b0;
               state_d      = ST_S_REL;
            end else if (timeout_hit_s) begin
               hs1_d        = 1'b0;
               rsp_data_d   = 32'h0000_0000;
               rsp_status_d = 32'h0000_0000;
               state_d      = ST_ABORT;
            end else begin
               state_d = ST_S_REQ;
            end
         end
         ST_S_REL: begin
            if (!bus_handshake_2) begin
               rsp_valid_d   = 1'b1;
               rsp_timeout_d = 1'b0;
               state_d       = ST_DONE;
            end else if (timeout_hit_s) begin
               hs1_d        = 1'b0;
               rsp_data_d   = 32'h0000_0000;
               rsp_status_d = 32'h0000_0000;
               state_d      = ST_ABORT;
            end else begin
               state_d = ST_S_REL;
            end
         end
         ST_ABORT: begin
            // Wait for a late acknowledge to release, but never forever.
            if (!bus_handshake_2 || timeout_hit_s) begin
               rsp_valid_d   = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_data_d    = 32'h0000_0000;
               rsp_status_d  = 32'h0000_0000;
               state_d       = ST_DONE;
            end else begin
               state_d = ST_ABORT;
            end
         end
         ST_DONE: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            hs1_d       = 1'b0;
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // Ready and timer follow the chosen next state.
   always_comb begin
      cmd_ready_d = (state_d == ST_IDLE);
      if (state_d != state_q) begin
         timer_d = {TW{1'b0}};
      end else if (counting_s) begin
         timer_d = timer_q + TW'(1);
      end else begin
         timer_d = {TW{1'b0}};
      end
   end

   assign cmd_ready       = cmd_ready_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_data        = rsp_data_q;
   assign rsp_status      = rsp_status_q;
   assign rsp_timeout     = rsp_timeout_q;
   assign bus_reg_address = addr_q;
   assign bus_RW          = rw_q;
   assign bus_data_out    = wdata_q;
   assign bus_handshake_1 = hs1_q;

endmodule
